// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux_scan_n block.
//   clog2_min1  : ceil(log2(n)), never less than 1. Sizes select and dwell-count fields.
//   MODE_MANUAL : mode encoding, the select follows sel_in.
//   MODE_AUTO   : mode encoding, the select is stepped by the dwell scanner.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // A one-value counter or a two-way select still needs one bit of storage.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// Bus bundle between the channel sources/controller and mux_scan_n.
// The master drives the controls and the packed channel data. The slave
// (the mux) returns the selected sample and its status flags.
//   en      : scanner enable, used in auto mode only
//   mode    : MODE_MANUAL / MODE_AUTO
//   sel_in  : manual channel select
//   d       : packed channel data, channel k at [k*W +: W]
//   y       : registered selected channel
//   sel_out : current internal select
//   wrap    : one-cycle pulse when the auto scan wraps back to channel 0
//   err     : registered out-of-range flag for the manual select
interface mux_scan_n_if #(
  parameter int N_CH = 4,
  parameter int W    = 1
);

  localparam int SEL_W = mux_scan_pkg::clog2_min1(N_CH);

  logic              en;
  logic              mode;
  logic [SEL_W-1:0]  sel_in;
  logic [N_CH*W-1:0] d;
  logic [W-1:0]      y;
  logic [SEL_W-1:0]  sel_out;
  logic              wrap;
  logic              err;

  modport master (
    output en, mode, sel_in, d,
    input  y, sel_out, wrap, err
  );

  modport slave (
    input  en, mode, sel_in, d,
    output y, sel_out, wrap, err
  );

endinterface

// File: rtl/mux_scan_n_dwell_counter.sv
// Dwell timer for the auto-scan mode.
// Counts enabled cycles from 0 to DWELL-1 and wraps. tick is high in the
// cycle where the count sits at DWELL-1 and en is high. That cycle is the
// last one the scanner spends on the current channel.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   clr  : synchronous clear, holds the count at 0
//   en   : count enable
//   tick : end-of-dwell strobe (combinational)
module dwell_counter
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W = clog2_min1(DWELL);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  // With DWELL=1 LAST is 0, so the counter never leaves 0 and tick follows en.
  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values that existed before this clock edge.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// Clocked N:1 multiplexer with a registered output and a built-in channel scanner.
// In manual mode the select follows sel_in, and out-of-range values are refused
// and flagged on err. In auto mode the select steps through all channels and
// stays DWELL enabled cycles on each one. wrap pulses on the N_CH-1 -> 0 step.
// The output register samples the selected channel every cycle in both modes.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, overrides every other input
//   bus : mux_scan_n_if slave modport (en, mode, sel_in, d -> y, sel_out, wrap, err)
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 1,
  parameter int DWELL = 2000
) (
  input  logic          clk,
  input  logic          rst,
  mux_scan_n_if.slave   bus
);

  localparam int               SEL_W   = clog2_min1(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] sel_cur;
  logic [W-1:0]     y_q;
  logic [W-1:0]     y_nxt;
  logic             wrap_q;
  logic             err_q;
  logic             tick;
  logic             sel_ok;
  logic             cnt_clr;
  logic             cnt_en;

  // The counter stays cleared in manual mode. The first auto edge after a
  // switch from manual therefore starts a fresh dwell on the kept channel.
  assign cnt_clr = (bus.mode == MODE_MANUAL);
  assign cnt_en  = bus.en && (bus.mode == MODE_AUTO);

  // A select can encode values above N_CH-1 when N_CH is not a power of two.
  assign sel_ok  = (int'(bus.sel_in) < N_CH);

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tick (tick)
  );

  // NOTE: every always_comb output gets a default first, so a select value
  // that matches no channel cannot leave y_nxt unassigned and infer a latch.
  always_comb begin
    y_nxt = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_cur == SEL_W'(k)) begin
        y_nxt = bus.d[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_cur <= '0;
      y_q     <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // y uses the select from before this edge, so sel_in -> y takes 2 cycles.
      y_q <= y_nxt;
      if (bus.mode == MODE_MANUAL) begin
        wrap_q <= 1'b0;
        err_q  <= !sel_ok;
        if (sel_ok) begin
          sel_cur <= bus.sel_in;
        end
      end else begin
        err_q  <= 1'b0;
        wrap_q <= tick && (sel_cur == LAST_CH);
        if (tick) begin
          sel_cur <= (sel_cur == LAST_CH) ? '0 : sel_cur + 1'b1;
        end
      end
    end
  end

  assign bus.y       = y_q;
  assign bus.sel_out = sel_cur;
  assign bus.wrap    = wrap_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Self-checking bench for mux_scan_n.
// Three instances share one clock:
//   dut0 : N_CH=4, DWELL=4
//   dut1 : N_CH=3, DWELL=4
//   dut2 : N_CH=4, DWELL=1
// Channel k carries a square wave with a half-period of 2^(3-k) cycles.
// A behavioural model tracks every instance and is compared at each negedge.
// Directed steps add constant expectations taken from the scan rules.
module tb_mux_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;

  logic       rst_v  [3];
  logic       en_v   [3];
  logic       mode_v [3];
  logic [1:0] sel_v  [3];
  logic [3:0] dv;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int   nch [3] = '{4, 3, 4};
  int   dwl [3] = '{4, 4, 1};
  int   m_sel [3];
  int   m_el  [3];   // cycles already spent on the current channel
  logic m_y    [3];
  logic m_wrap [3];
  logic m_err  [3];

  function automatic logic sq(input int k, input int c);
    return ((c >> (3 - k)) & 1) != 0;
  endfunction

  assign dv = {sq(3, cyc), sq(2, cyc), sq(1, cyc), sq(0, cyc)};

  mux_scan_n_if #(.N_CH(4), .W(1)) bus0 ();
  mux_scan_n_if #(.N_CH(3), .W(1)) bus1 ();
  mux_scan_n_if #(.N_CH(4), .W(1)) bus2 ();

  assign bus0.en = en_v[0];  assign bus0.mode = mode_v[0];  assign bus0.sel_in = sel_v[0];  assign bus0.d = dv;
  assign bus1.en = en_v[1];  assign bus1.mode = mode_v[1];  assign bus1.sel_in = sel_v[1];  assign bus1.d = dv[2:0];
  assign bus2.en = en_v[2];  assign bus2.mode = mode_v[2];  assign bus2.sel_in = sel_v[2];  assign bus2.d = dv;

  mux_scan_n #(.N_CH(4), .W(1), .DWELL(4)) dut0 (.clk(clk), .rst(rst_v[0]), .bus(bus0));
  mux_scan_n #(.N_CH(3), .W(1), .DWELL(4)) dut1 (.clk(clk), .rst(rst_v[1]), .bus(bus1));
  mux_scan_n #(.N_CH(4), .W(1), .DWELL(1)) dut2 (.clk(clk), .rst(rst_v[2]), .bus(bus2));

  function automatic logic [31:0] obs_sel(input int id);
    case (id)
      0:       return {30'd0, bus0.sel_out};
      1:       return {30'd0, bus1.sel_out};
      default: return {30'd0, bus2.sel_out};
    endcase
  endfunction

  function automatic logic obs_y(input int id);
    case (id)
      0:       return bus0.y;
      1:       return bus1.y;
      default: return bus2.y;
    endcase
  endfunction

  function automatic logic obs_wrap(input int id);
    case (id)
      0:       return bus0.wrap;
      1:       return bus1.wrap;
      default: return bus2.wrap;
    endcase
  endfunction

  function automatic logic obs_err(input int id);
    case (id)
      0:       return bus0.err;
      1:       return bus1.err;
      default: return bus2.err;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model of one clock edge, taken from the behavioural rules.
  task automatic model_update();
    for (int id = 0; id < 3; id++) begin
      if (rst_v[id]) begin
        m_sel[id] = 0; m_el[id] = 0; m_y[id] = 1'b0; m_wrap[id] = 1'b0; m_err[id] = 1'b0;
      end else begin
        m_y[id] = sq(m_sel[id], cyc);
        m_wrap[id] = 1'b0;
        if (mode_v[id] == 1'b0) begin
          m_el[id] = 0;
          m_err[id] = (int'(sel_v[id]) >= nch[id]);
          if (!m_err[id]) m_sel[id] = int'(sel_v[id]);
        end else begin
          m_err[id] = 1'b0;
          if (en_v[id]) begin
            m_el[id]++;
            if (m_el[id] == dwl[id]) begin
              m_el[id] = 0;
              m_wrap[id] = (m_sel[id] == nch[id] - 1);
              m_sel[id] = (m_sel[id] + 1) % nch[id];
            end
          end
        end
      end
    end
  endtask

  // One clock: model the edge, compare all instances at the negedge, then move the data.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    for (int id = 0; id < 3; id++) begin
      check($sformatf("dut%0d_sel_out", id), obs_sel(id), 32'(m_sel[id]));
      check($sformatf("dut%0d_y", id), {31'd0, obs_y(id)}, {31'd0, m_y[id]});
      check($sformatf("dut%0d_wrap", id), {31'd0, obs_wrap(id)}, {31'd0, m_wrap[id]});
      check($sformatf("dut%0d_err", id), {31'd0, obs_err(id)}, {31'd0, m_err[id]});
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int found, run, wraps, first_wrap, last_wrap, gap, bad;

    for (int id = 0; id < 3; id++) begin
      rst_v[id] = 1'b1; en_v[id] = 1'b0; mode_v[id] = 1'b0; sel_v[id] = 2'd0;
    end
    cycle();
    cycle();
    for (int id = 0; id < 3; id++) begin
      check($sformatf("reset_sel_dut%0d", id), obs_sel(id), 32'd0);
      check($sformatf("reset_y_dut%0d", id), {31'd0, obs_y(id)}, 32'd0);
    end
    for (int id = 0; id < 3; id++) rst_v[id] = 1'b0;

    // 1. Reset in the middle of a scan.
    mode_v[0] = 1'b1; en_v[0] = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (obs_sel(0) == 32'd2) begin found = 1; break; end
    end
    check("t1_reach_sel2", 32'(found), 32'd1);
    cycle();
    rst_v[0] = 1'b1;
    cycle();
    rst_v[0] = 1'b0;
    check("t1_rst_sel", obs_sel(0), 32'd0);
    check("t1_rst_y", {31'd0, obs_y(0)}, 32'd0);
    check("t1_rst_wrap", {31'd0, obs_wrap(0)}, 32'd0);
    run = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_sel(0) == 32'd0) run++; else break;
    end
    check("t1_ch0_dwell", 32'(run), 32'd4);

    // 2. Manual select of every channel.
    mode_v[0] = 1'b0; en_v[0] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel_v[0] = 2'(s);
      cycle();
      check($sformatf("t2_sel_follow_%0d", s), obs_sel(0), 32'(s));
      for (int i = 0; i < 9; i++) cycle();
      check($sformatf("t2_err_%0d", s), {31'd0, obs_err(0)}, 32'd0);
    end

    // 3. Auto scan from channel 0.
    sel_v[0] = 2'd0;
    cycle();
    mode_v[0] = 1'b1; en_v[0] = 1'b1;
    wraps = 0; first_wrap = -1; last_wrap = -1; gap = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (obs_sel(0) != 32'((i / 4) % 4)) bad++;
      if (obs_wrap(0) === 1'b1) begin
        wraps++;
        if (first_wrap < 0) first_wrap = i; else gap = i - last_wrap;
        last_wrap = i;
      end
    end
    check("t3_sequence_errors", 32'(bad), 32'd0);
    check("t3_wrap_count", 32'(wraps), 32'd2);
    check("t3_first_wrap", 32'(first_wrap), 32'd16);
    check("t3_wrap_period", 32'(gap), 32'd16);

    // 4. Enable gating on channel 1.
    mode_v[0] = 1'b0; sel_v[0] = 2'd1;
    cycle();
    run = (obs_sel(0) == 32'd1) ? 1 : 0;
    mode_v[0] = 1'b1;
    en_v[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin cycle(); if (obs_sel(0) == 32'd1) run++; end
    en_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin cycle(); if (obs_sel(0) == 32'd1) run++; end
    check("t4_frozen_sel", obs_sel(0), 32'd1);
    en_v[0] = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (obs_sel(0) == 32'd1) run++; else begin found = 1; break; end
    end
    check("t4_left_ch1", 32'(found), 32'd1);
    check("t4_ch1_total", 32'(run), 32'd9);

    // 5. N_CH=3: out-of-range manual select, then auto wrap 2 -> 0.
    sel_v[1] = 2'd1;
    for (int i = 0; i < 3; i++) cycle();
    sel_v[1] = 2'd3;
    cycle();
    cycle();
    check("t5_err", {31'd0, obs_err(1)}, 32'd1);
    check("t5_sel_hold", obs_sel(1), 32'd1);
    mode_v[1] = 1'b1; en_v[1] = 1'b1;
    wraps = 0; bad = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (obs_sel(1) == 32'd3) bad++;
      if (obs_wrap(1) === 1'b1) wraps++;
    end
    check("t5_never_3", 32'(bad), 32'd0);
    check("t5_wrap_count", 32'(wraps), 32'd2);
    check("t5_err_auto", {31'd0, obs_err(1)}, 32'd0);

    // 6. Manual -> auto keeps the channel. DWELL=1 steps every cycle.
    mode_v[0] = 1'b0; en_v[0] = 1'b1; sel_v[0] = 2'd2;
    cycle();
    cycle();
    mode_v[0] = 1'b1; sel_v[0] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("t6_hold2_%0d", i), obs_sel(0), 32'd2);
    end
    cycle();
    check("t6_adv3", obs_sel(0), 32'd3);
    mode_v[2] = 1'b1; en_v[2] = 1'b1;
    wraps = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      check($sformatf("t6_dwell1_%0d", i), obs_sel(2), 32'(i % 4));
      if (obs_wrap(2) === 1'b1) wraps++;
    end
    check("t6_dwell1_wraps", 32'(wraps), 32'd2);

    // Randomised traffic on all instances against the model.
    for (int i = 0; i < 300; i++) begin
      for (int id = 0; id < 3; id++) begin
        rst_v[id] = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 7) == 0) mode_v[id] = ~mode_v[id];
        en_v[id] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) sel_v[id] = 2'($urandom_range(0, 3));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_n.md
# mux_scan_n

Clocked, parametrised N:1 multiplexer with registered output and a built-in channel scanner. It generalises the lab 4:1 mux to N channels of W bits. It adds an auto-scan mode that steps the select through all channels with a programmable dwell time, so a bench or top level can cycle square-wave sources without driving `sel` externally. It sits between multi-channel signal sources and a single observation/output path.

## Interface
- `N_CH`, default 4: number of input channels, 2 or more, power of two not required.
- `W`, default 1: bits per channel.
- `DWELL`, default 2000: clock cycles spent on each channel in auto mode, 1 or more.
- `SEL_W`, derived as `$clog2(N_CH)`: select width.

- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `en`  in  1: scanner enable (auto mode only).
- `mode`  in  1: 0 = manual (select from `sel_in`), 1 = auto-scan.
- `sel_in`  in  SEL_W: manual channel select.
- `d`  in  N_CH*W: packed data, channel k at bits [k*W +: W].
- `y`  out  W: registered selected channel.
- `sel_out`  out  SEL_W: current internal select (`sel_cur`).
- `wrap`  out  1: one-cycle pulse when auto scan wraps from channel N_CH-1 to 0.
- `err`  out  1: registered flag, 1 while `sel_in` is N_CH or greater in manual mode.

## Operation
- Reset (rst=1 at an edge) drives `y`, `sel_out`, `wrap`, `err` and the dwell counter `cnt` to 0. Reset takes priority over every other input, including mid-dwell and mid-scan.
- Manual mode (mode=0):
  - `sel_cur <= sel_in` every cycle.
  - `cnt` is held at 0 and `wrap` is 0.
  - If `sel_in` is N_CH or greater, `sel_cur` holds its previous value and `err <= 1`. Otherwise `err <= 0`.
- Auto mode (mode=1):
  - `err <= 0` and `sel_in` is ignored.
  - When en=1:
    - If `cnt == DWELL-1`: `cnt <= 0`, and `sel_cur <= (sel_cur == N_CH-1) ? 0 : sel_cur+1`.
    - Otherwise: `cnt <= cnt+1`.
  - When en=0, `cnt` and `sel_cur` freeze. `y` keeps sampling the data.
  - `wrap <= 1` only on the edge where `sel_cur` goes from N_CH-1 to 0.
- Mode 0→1 transition: `sel_cur` is kept (the scan starts from the last manual channel) and `cnt <= 0`.
- Mode 1→0 transition: `sel_cur` follows `sel_in` from the next edge.
- Output: `y <= d[sel_cur*W +: W]` every cycle, independent of `en` and `mode`.
- `cnt` width is `$clog2(DWELL)`, minimum 1 bit. With DWELL=1 the select advances on every enabled cycle.

## Timing
- `d` → `y`: 1 cycle.
- `sel_in` → `sel_out`: 1 cycle.
- `sel_in` → `y`: 2 cycles.
- In auto mode with continuous `en`, each channel is selected for exactly DWELL cycles. A full scan lasts N_CH*DWELL cycles, and `wrap` pulses once per scan.
- `err` is valid 1 cycle after `sel_in`.
- First `y` after reset deassertion is `d[0]` (rst low at edge t, `y` equals channel 0 data after edge t+1).

## Structure
- Package `mux_scan_pkg` holds:
  - the `SEL_W` / count-width helper (a clog2-with-minimum-1 function);
  - the mode encoding constants `MODE_MANUAL = 1'b0` and `MODE_AUTO = 1'b1`.
- One sub-module, `dwell_counter`:
  - parameter `DWELL`;
  - inputs `clk`, `rst`, `clr`, `en`;
  - output `tick`, high in the cycle where `cnt == DWELL-1` and `en` is 1.
- The top level holds `sel_cur`, the wrap/err logic, and the output mux register.

## Test plan
The bench uses N_CH=4, W=1, DWELL=4 unless stated. Channel k is driven as a square wave with half-period 2^(3-k) cycles.

1. **Reset mid-scan:** in auto mode with en=1, pulse rst for 1 cycle while `sel_out`=2 → next cycle `sel_out`=0, `y`=0, `wrap`=0, `cnt` restarts; channel 0 is held for 4 cycles.
2. **Manual select:** set `sel_in`=0,1,2,3, each for 10 cycles → `sel_out` follows after 1 cycle and `y` matches `d[sel_in]` delayed 2 cycles; `err`=0 throughout.
3. **Auto scan:** mode=1, en=1 from channel 0 → `sel_out` sequence is 0,0,0,0,1,1,1,1,2…3,3,3,3,0; `wrap` is high for exactly 1 cycle at the 3→0 edge, every 16 cycles.
4. **Enable gating:** en=0 for 5 cycles while on channel 1, after 2 dwell cycles → `sel_out` stays 1 and channel 1 then lasts 4+5 cycles in total; `y` keeps tracking `d[1]`.
5. **Non-power-of-two and out-of-range select:** N_CH=3, manual `sel_in`=3 → `err`=1 and `sel_out` holds its previous value. In auto mode the scan wraps 2→0, never reaching 3.
6. **Mode switch and DWELL=1:** switch mode 0→1 with `sel_in`=2 → scan starts at 2 and advances after 4 cycles to 3. With DWELL=1, `sel_out` increments on every cycle.
